// File: rtl/missile_pkg.sv
// Shared types and constants for the missile slot scheduler and its per-slot lifecycle FSM.
package missile_pkg;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_FLIGHT,
      SLOT_EXPLODE
   } slot_state_e;

   localparam int unsigned Y_W     = 10;
   localparam int unsigned FRAME_W = 3;

   localparam logic [Y_W-1:0] GROUND_Y_DEFAULT = 10'd390;

   localparam int unsigned REQ_PLAYER = 0;
   localparam int unsigned REQ_ENEMY  = 1;

endpackage

// File: rtl/missile_slot_fsm.sv
// Lifecycle of one missile slot: IDLE -> FLIGHT -> EXPLODE -> IDLE, with a
// frame-timed explosion counter and a flight arm flag that masks stale Y.
module missile_slot_fsm
   import missile_pkg::*;
#(
   parameter logic [Y_W-1:0] GROUND_Y       = GROUND_Y_DEFAULT,
   parameter int unsigned    EXPLODE_FRAMES = 6
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               alloc,
   input  logic               hit,
   input  logic [Y_W-1:0]     y,
   output logic               active,
   output logic               exploding,
   output logic [FRAME_W-1:0] explode_frame,
   output logic               idle,
   output logic               idle_next_c
);

   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(EXPLODE_FRAMES - 1);

   slot_state_e        state;
   slot_state_e        state_next;
   logic               armed;
   logic               armed_next;
   logic [FRAME_W-1:0] frame_next;

   // Next-state: hit always detonates; ground only once a frame has passed in flight.
   always_comb begin
      state_next = state;
      armed_next = armed;
      frame_next = explode_frame;
      case (state)
         SLOT_IDLE: begin
            if (alloc) begin
               state_next = SLOT_FLIGHT;
               armed_next = 1'b0;
            end
         end
         SLOT_FLIGHT: begin
            if (frame_tick) armed_next = 1'b1;
            if (hit || (armed && (y >= GROUND_Y))) begin
               state_next = SLOT_EXPLODE;
               frame_next = '0;
            end
         end
         SLOT_EXPLODE: begin
            if (frame_tick) begin
               if (explode_frame == LAST_FRAME) begin
                  state_next = SLOT_IDLE;
                  frame_next = '0;
               end else begin
                  frame_next = explode_frame + FRAME_W'(1);
               end
            end
         end
         default: state_next = SLOT_IDLE;
      endcase
      idle_next_c = (state_next == SLOT_IDLE);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= SLOT_IDLE;
         armed         <= 1'b0;
         explode_frame <= '0;
         active        <= 1'b0;
         exploding     <= 1'b0;
         idle          <= 1'b1;
      end else begin
         state         <= state_next;
         armed         <= armed_next;
         explode_frame <= frame_next;
         active        <= (state_next == SLOT_FLIGHT);
         exploding     <= (state_next == SLOT_EXPLODE);
         idle          <= idle_next_c;
      end
   end

endmodule

// File: rtl/missile_slot_scheduler.sv
// Shares a pool of missile slots between player and enemy requesters with
// round-robin arbitration, and runs every slot through its lifecycle FSM.
module missile_slot_scheduler
   import missile_pkg::*;
#(
   parameter int unsigned    N_SLOTS        = 4,
   parameter int unsigned    SLOT_W         = 2,
   parameter logic [Y_W-1:0] GROUND_Y       = GROUND_Y_DEFAULT,
   parameter int unsigned    EXPLODE_FRAMES = 6
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_tick,
   input  logic [1:0]                 req,
   output logic [1:0]                 grant,
   output logic [SLOT_W-1:0]          grant_slot,
   output logic [N_SLOTS-1:0]         launch,
   input  logic [N_SLOTS-1:0]         hit,
   input  logic [N_SLOTS*Y_W-1:0]     missile_y,
   output logic [N_SLOTS-1:0]         active,
   output logic [N_SLOTS-1:0]         exploding,
   output logic [N_SLOTS*FRAME_W-1:0] explode_frame,
   output logic                       pool_full
);

   logic                rr_ptr;
   logic [N_SLOTS-1:0]  idle;
   logic [N_SLOTS-1:0]  idle_next_c;
   logic [N_SLOTS-1:0]  alloc_c;
   logic                alloc_en_c;
   logic                winner_c;
   logic [SLOT_W-1:0]   free_slot_c;

   // Lowest-index idle slot; scanning downward lets the lowest index win.
   always_comb begin
      free_slot_c = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (idle[i]) free_slot_c = SLOT_W'(i);
      end
   end

   // A lone requester wins outright; contention goes to rr_ptr.
   always_comb begin
      case (req)
         2'b01:   winner_c = 1'(REQ_PLAYER);
         2'b10:   winner_c = 1'(REQ_ENEMY);
         default: winner_c = rr_ptr;
      endcase
      alloc_en_c = (req != 2'b00) && (|idle);
      alloc_c    = alloc_en_c ? (N_SLOTS'(1) << free_slot_c) : '0;
   end

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      missile_slot_fsm #(
         .GROUND_Y       (GROUND_Y),
         .EXPLODE_FRAMES (EXPLODE_FRAMES)
      ) u_fsm (
         .Clk           (Clk),
         .Reset         (Reset),
         .frame_tick    (frame_tick),
         .alloc         (alloc_c[g]),
         .hit           (hit[g]),
         .y             (missile_y[g*Y_W +: Y_W]),
         .active        (active[g]),
         .exploding     (exploding[g]),
         .explode_frame (explode_frame[g*FRAME_W +: FRAME_W]),
         .idle          (idle[g]),
         .idle_next_c   (idle_next_c[g])
      );
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grant      <= 2'b00;
         grant_slot <= '0;
         launch     <= '0;
         rr_ptr     <= 1'(REQ_PLAYER);
         pool_full  <= 1'b0;
      end else begin
         grant      <= alloc_en_c ? (2'b01 << winner_c) : 2'b00;
         grant_slot <= alloc_en_c ? free_slot_c : '0;
         launch     <= alloc_c;
         pool_full  <= ~|idle_next_c;
         if (alloc_en_c) rr_ptr <= ~winner_c;
      end
   end

endmodule

// File: tb/tb_missile_slot_scheduler.sv
// Self-checking bench for missile_slot_scheduler: expected grants are queued
// as requests are driven and matched when the DUT grants.
module tb_missile_slot_scheduler;

   localparam int unsigned N_SLOTS = 4;
   localparam int unsigned SLOT_W  = 2;

   typedef struct packed {
      logic [1:0]        g;
      logic [SLOT_W-1:0] s;
   } exp_t;

   logic                   Clk;
   logic                   Reset;
   logic                   frame_tick;
   logic [1:0]             req;
   logic [1:0]             grant;
   logic [SLOT_W-1:0]      grant_slot;
   logic [N_SLOTS-1:0]     launch;
   logic [N_SLOTS-1:0]     hit;
   logic [N_SLOTS*10-1:0]  missile_y;
   logic [N_SLOTS-1:0]     active;
   logic [N_SLOTS-1:0]     exploding;
   logic [N_SLOTS*3-1:0]   explode_frame;
   logic                   pool_full;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   missile_slot_scheduler #(
      .N_SLOTS        (N_SLOTS),
      .SLOT_W         (SLOT_W),
      .GROUND_Y       (10'd390),
      .EXPLODE_FRAMES (6)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_tick    (frame_tick),
      .req           (req),
      .grant         (grant),
      .grant_slot    (grant_slot),
      .launch        (launch),
      .hit           (hit),
      .missile_y     (missile_y),
      .active        (active),
      .exploding     (exploding),
      .explode_frame (explode_frame),
      .pool_full     (pool_full)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   task automatic expect_grant(input logic [1:0] g, input logic [SLOT_W-1:0] s);
      exp_t e;
      e.g = g;
      e.s = s;
      sb.push_back(e);
   endtask

   task automatic frame_pulse();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   function automatic logic [2:0] frame_of(input int slot);
      return explode_frame[slot*3 +: 3];
   endfunction

   // Grant monitor: every grant must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (grant !== 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_grant", 32'(grant), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("grant", 32'(grant), 32'(e.g));
            chk("grant_slot", 32'(grant_slot), 32'(e.s));
            chk("launch", 32'(launch), 32'(N_SLOTS'(1) << e.s));
         end
      end else if (launch !== '0) begin
         chk("launch_without_grant", 32'(launch), 32'(0));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      Reset      = 1'b1;
      req        = 2'b00;
      hit        = '0;
      frame_tick = 1'b0;
      missile_y  = '0;
      repeat (2) step();
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_active", 32'(active), 32'(0));
      chk("rst_pool_full", 32'(pool_full), 32'(0));
      Reset = 1'b0;
      step();

      // Single player request
      req = 2'b01;
      expect_grant(2'b01, 2'd0);
      step();
      req = 2'b00;
      chk("t1_active", 32'(active), 32'h1);
      chk("t1_pool_full", 32'(pool_full), 32'(0));
      step();
      chk("t1_launch_drop", 32'(launch), 32'(0));

      // Contention from a fresh reset: alternate player/enemy across all slots
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      chk("t2_active_clear", 32'(active), 32'(0));
      req = 2'b11;
      expect_grant(2'b01, 2'd0);
      expect_grant(2'b10, 2'd1);
      expect_grant(2'b01, 2'd2);
      expect_grant(2'b10, 2'd3);
      repeat (3) step();
      chk("t2_not_full", 32'(pool_full), 32'(0));
      step();
      chk("t2_full", 32'(pool_full), 32'(1));
      chk("t2_active_all", 32'(active), 32'hF);
      repeat (3) step();
      req = 2'b00;
      step();

      // Stale Y before the first frame in flight must not detonate
      missile_y[9:0] = 10'd400;
      repeat (3) step();
      chk("t3_stale_y", 32'(exploding[0]), 32'(0));
      frame_pulse();
      chk("t3_arm_edge", 32'(exploding[0]), 32'(0));
      step();
      chk("t3_ground_explode", 32'(exploding[0]), 32'(1));
      chk("t3_active_off", 32'(active[0]), 32'(0));

      // Hit on slot 1, then six-frame explosion
      hit[1] = 1'b1;
      step();
      hit[1] = 1'b0;
      chk("t4_exploding", 32'(exploding[1]), 32'(1));
      chk("t4_frame0", 32'(frame_of(1)), 32'(0));
      for (int k = 1; k <= 6; k++) begin
         frame_pulse();
         if (k < 6) begin
            chk("t4_frame", 32'(frame_of(1)), 32'(k));
            chk("t4_still_exploding", 32'(exploding[1]), 32'(1));
         end else begin
            chk("t4_frame_wrap", 32'(frame_of(1)), 32'(0));
            chk("t4_explode_done", 32'(exploding[1]), 32'(0));
            chk("t4_active_done", 32'(active[1]), 32'(0));
         end
      end
      // Both freed slots are re-granted; slot 0 first, then slot 1
      missile_y[9:0] = 10'd0;
      req = 2'b01;
      expect_grant(2'b01, 2'd0);
      expect_grant(2'b01, 2'd1);
      step();
      step();
      req = 2'b00;
      chk("t4_refill_full", 32'(pool_full), 32'(1));

      // Pool full; slot 2 finishes while enemy waits
      hit[2] = 1'b1;
      req    = 2'b10;
      step();
      hit[2] = 1'b0;
      chk("t5_exploding", 32'(exploding[2]), 32'(1));
      for (int k = 1; k <= 6; k++) frame_pulse();
      chk("t5_no_same_cycle", 32'(grant), 32'(0));
      chk("t5_slot_idle", 32'(exploding[2]), 32'(0));
      chk("t5_pool_open", 32'(pool_full), 32'(0));
      expect_grant(2'b10, 2'd2);
      step();
      req = 2'b00;
      chk("t5_refull", 32'(pool_full), 32'(1));
      chk("t5_active2", 32'(active[2]), 32'(1));

      // Asynchronous reset mid-explosion
      hit[3] = 1'b1;
      step();
      hit[3] = 1'b0;
      frame_pulse();
      chk("t6_frame1", 32'(frame_of(3)), 32'(1));
      #2;
      Reset = 1'b1;
      #1;
      chk("t6_rst_active", 32'(active), 32'(0));
      chk("t6_rst_exploding", 32'(exploding), 32'(0));
      chk("t6_rst_frame", 32'(explode_frame), 32'(0));
      chk("t6_rst_pool_full", 32'(pool_full), 32'(0));
      chk("t6_rst_grant", 32'(grant), 32'(0));
      chk("t6_rst_launch", 32'(launch), 32'(0));
      step();
      Reset = 1'b0;
      req   = 2'b11;
      expect_grant(2'b01, 2'd0);
      step();
      req = 2'b00;
      chk("t6_active0", 32'(active), 32'h1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      chk("sb_drain", 32'(sb.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
